clock_mode_ctrl: RTL

Sequencing controller for the digital clock's three up/down modulo counters (seconds, minutes, hours). It turns a 1 Hz tick into the seconds→minutes→hours carry chain in run mode. It also provides a button-driven adjust mode that steps the minutes or hours counter up or down. It sits between the debounced button/tick sources and the `enable`/`updown` inputs of the counter instances, and reads their `count` outputs back.

---
 rtl/clock_mode_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// Run/adjust sequencer for the seconds/minutes/hours modulo counters: builds the
// 1 Hz carry chain in RUN and button-driven single steps of one field in adjust modes.
module clock_mode_ctrl #(
    parameter int SEC_N = 60,
    parameter int MIN_N = 60,
    parameter int HR_N  = 24,
    parameter int SEC_W = 6,
    parameter int MIN_W = 6,
    parameter int HR_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             btn_center,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [SEC_W-1:0] sec_count,
    input  logic [MIN_W-1:0] min_count,
    input  logic [HR_W-1:0]  hr_count,
    output logic             sec_en,
    output logic             min_en,
    output logic             hr_en,
    output logic             updown,
    output logic [1:0]       mode,
    output logic             blink
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        ADJ_MIN = 2'b01,
        ADJ_HR  = 2'b10
    } state_t;

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_N - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_N - 1);
    localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_N - 1);

    state_t state_q, state_d;
    logic   sec_en_q, sec_en_d;
    logic   min_en_q, min_en_d;
    logic   hr_en_q, hr_en_d;
    logic   updown_q, updown_d;
    logic   blink_q, blink_d;

    logic step_up, step_dn;
    logic sec_at_max, min_at_max;
    logic min_dn_ok, hr_dn_ok;

    assign step_up    = btn_up & ~btn_down;
    assign step_dn    = btn_down & ~btn_up;
    assign sec_at_max = (sec_count == SEC_MAX);
    assign min_at_max = (min_count == MIN_MAX);
    // Down-steps at 0 or N-1 are withheld so the counters never see them.
    assign min_dn_ok  = (min_count != '0) && (min_count != MIN_MAX);
    assign hr_dn_ok   = (hr_count != '0) && (hr_count != HR_MAX);

    always_comb begin
        state_d  = state_q;
        sec_en_d = 1'b0;
        min_en_d = 1'b0;
        hr_en_d  = 1'b0;
        updown_d = updown_q;
        case (state_q)
            RUN: begin
                if (btn_center) state_d = ADJ_MIN;
                if (tick_1hz) begin
                    sec_en_d = 1'b1;
                    updown_d = 1'b1;
                    min_en_d = sec_at_max;
                    hr_en_d  = sec_at_max && min_at_max;
                end
            end
            ADJ_MIN: begin
                if (btn_center) begin
                    state_d = RUN;
                end else begin
                    if (btn_left) state_d = ADJ_HR;
                    if (step_up) begin
                        min_en_d = 1'b1;
                        updown_d = 1'b1;
                    end else if (step_dn && min_dn_ok) begin
                        min_en_d = 1'b1;
                        updown_d = 1'b0;
                    end
                end
            end
            ADJ_HR: begin
                if (btn_center) begin
                    state_d = RUN;
                end else begin
                    if (btn_right) state_d = ADJ_MIN;
                    if (step_up) begin
                        hr_en_d  = 1'b1;
                        updown_d = 1'b1;
                    end else if (step_dn && hr_dn_ok) begin
                        hr_en_d  = 1'b1;
                        updown_d = 1'b0;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // Blink restarts lit whenever a field is newly selected.
        if (state_d == RUN) begin
            blink_d = 1'b0;
        end else if (state_d != state_q) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            sec_en_q <= 1'b0;
            min_en_q <= 1'b0;
            hr_en_q  <= 1'b0;
            updown_q <= 1'b1;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sec_en_q <= sec_en_d;
            min_en_q <= min_en_d;
            hr_en_q  <= hr_en_d;
            updown_q <= updown_d;
            blink_q  <= blink_d;
        end
    end

    assign sec_en = sec_en_q;
    assign min_en = min_en_q;
    assign hr_en  = hr_en_q;
    assign updown = updown_q;
    assign mode   = state_q;
    assign blink  = blink_q;

endmodule
